// File: rtl/fly_wave_scheduler.sv
// Wave sequencer for the 17-fly formation: spawn pulse, settle, move, clear, intermission.
// Optional macro FLY_WAVE_SPEEDUP_EN: bump speed_level on every new wave (saturating at 7).
module fly_wave_scheduler #(
  parameter int NUM_FLY          = 17,
  parameter int SPAWN_HOLD       = 2,
  parameter int INTERMISSION_CYC = 25_000_000,
  parameter int MAX_WAVE         = 8
) (
  input  logic               clk25,
  input  logic               reset_n,
  input  logic               game_start,
  input  logic               pause,
  input  logic               player_dead,
  input  logic [NUM_FLY-1:0] fly_alive,
  output logic               reset_fly,
  output logic               move_en,
  output logic [2:0]         speed_level,
  output logic [7:0]         wave_num,
  output logic               wave_clear,
  output logic               game_won,
  output logic               game_lost
);

  localparam int CNT_MAX = (INTERMISSION_CYC > SPAWN_HOLD) ? INTERMISSION_CYC : SPAWN_HOLD;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {IDLE, SPAWN, GUARD, ACTIVE, INTER, DONE, LOST} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [NUM_FLY-1:0] alive_q;
  logic               in_wave;

  assign in_wave = (state == SPAWN) || (state == GUARD) || (state == ACTIVE) || (state == INTER);

  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      alive_q     <= '0;
      reset_fly   <= 1'b0;
      move_en     <= 1'b0;
      speed_level <= 3'd0;
      wave_num    <= 8'd0;
      wave_clear  <= 1'b0;
      game_won    <= 1'b0;
      game_lost   <= 1'b0;
    end else begin
      alive_q    <= fly_alive;
      wave_clear <= 1'b0;
      // Death outranks pause and a same-cycle clear.
      if (in_wave && player_dead) begin
        state     <= LOST;
        reset_fly <= 1'b0;
        move_en   <= 1'b0;
        game_lost <= 1'b1;
      end else if (pause) begin
        move_en <= 1'b0;
      end else begin
        case (state)
          IDLE, DONE, LOST: begin
            if (game_start) begin
              state       <= SPAWN;
              cnt         <= '0;
              reset_fly   <= 1'b1;
              wave_num    <= 8'd1;
              speed_level <= 3'd0;
              game_won    <= 1'b0;
              game_lost   <= 1'b0;
            end
          end
          SPAWN: begin
            if (cnt == CW'(SPAWN_HOLD - 1)) begin
              state     <= GUARD;
              reset_fly <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          GUARD: begin
            state   <= ACTIVE;
            move_en <= 1'b1;
          end
          ACTIVE: begin
            if (alive_q == '0) begin
              wave_clear <= 1'b1;
              move_en    <= 1'b0;
              if (wave_num == 8'(MAX_WAVE)) begin
                state    <= DONE;
                game_won <= 1'b1;
              end else begin
                state <= INTER;
                cnt   <= CW'(INTERMISSION_CYC - 1);
              end
            end else begin
              move_en <= 1'b1;
            end
          end
          INTER: begin
            if (cnt == '0) begin
              state     <= SPAWN;
              reset_fly <= 1'b1;
              wave_num  <= wave_num + 8'd1;
`ifdef FLY_WAVE_SPEEDUP_EN
              if (speed_level != 3'd7) speed_level <= speed_level + 3'd1;
`endif
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fly_wave_scheduler.sv
// Randomized bench for fly_wave_scheduler; expectations come from wave-level timing rules.
module tb_fly_wave_scheduler;
  localparam int NF = 17;
  localparam int SH = 2;
  localparam int IC = 4;
  localparam int MW = 3;

  logic          clk25 = 1'b0;
  logic          reset_n = 1'b0;
  logic          game_start = 1'b0;
  logic          pause = 1'b0;
  logic          player_dead = 1'b0;
  logic [NF-1:0] fly_alive = '1;
  logic          reset_fly, move_en, wave_clear, game_won, game_lost;
  logic [2:0]    speed_level;
  logic [7:0]    wave_num;

  int total = 0;
  int bad   = 0;
  int m_wave = 0;

  fly_wave_scheduler #(.NUM_FLY(NF), .SPAWN_HOLD(SH), .INTERMISSION_CYC(IC), .MAX_WAVE(MW)) dut (
    .clk25(clk25), .reset_n(reset_n), .game_start(game_start), .pause(pause),
    .player_dead(player_dead), .fly_alive(fly_alive), .reset_fly(reset_fly),
    .move_en(move_en), .speed_level(speed_level), .wave_num(wave_num),
    .wave_clear(wave_clear), .game_won(game_won), .game_lost(game_lost)
  );

  always #20 clk25 = ~clk25;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk25);
    #1;
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return reset_fly;
      1:       return move_en;
      2:       return wave_clear;
      3:       return game_won;
      default: return game_lost;
    endcase
  endfunction

  // Ticks until the selected output equals v; stops at lim so a stuck DUT cannot hang the run.
  task automatic wait_sig(input int sel, input logic v, input int lim, output int n);
    n = 0;
    while (sig(sel) !== v && n < lim) begin
      tick();
      n++;
    end
  endtask

  function automatic int exp_speed(input int w);
`ifdef FLY_WAVE_SPEEDUP_EN
    return (w - 1 > 7) ? 7 : w - 1;
`else
    return 0;
`endif
  endfunction

  task automatic rand_alive();
    logic [NF-1:0] one;
    one = 1;
    fly_alive = NF'($urandom) | (one << $urandom_range(NF - 1, 0));
  endtask

  // Spawn phase through first movement of a wave.
  task automatic spawn_to_move(input string tag);
    int n;
    rand_alive();
    wait_sig(0, 1'b0, 30, n);
    chk({tag, "_spawn_hold"}, n, SH);
    wait_sig(1, 1'b1, 30, n);
    chk({tag, "_guard"}, n, 1);
  endtask

  task automatic start_game();
    int n;
    game_start = 1'b1;
    wait_sig(0, 1'b1, 30, n);
    game_start = 1'b0;
    chk("start_latency", n, 1);
    m_wave = 1;
    chk("start_wave", wave_num, 1);
    chk("start_speed", speed_level, 0);
    chk("start_won", game_won, 0);
    chk("start_lost", game_lost, 0);
    spawn_to_move("w1");
  endtask

  task automatic active_hold();
    int h, wc, me;
    h = $urandom_range(3, 8);
    wc = 0;
    me = 1;
    game_start = 1'b1;
    tick();
    game_start = 1'b0;
    chk("ignored_start_wave", wave_num, m_wave);
    chk("ignored_start_spawn", reset_fly, 0);
    for (int i = 0; i < h; i++) begin
      rand_alive();
      tick();
      wc += int'(wave_clear);
      if (!move_en) me = 0;
    end
    chk("no_clear_alive", wc, 0);
    chk("move_en_active", me, 1);
  endtask

  task automatic clear_wave(input int pause_len, input bit pause_active);
    int n, n2, k, wc;
    if (pause_active) begin
      pause = 1'b1;
      fly_alive = '0;
      wc = 0;
      repeat (5) begin
        tick();
        wc += int'(wave_clear);
      end
      chk("pause_no_clear", wc, 0);
      chk("pause_move_en", move_en, 0);
      pause = 1'b0;
      wait_sig(2, 1'b1, 30, n);
      chk("clear_after_unpause", n, 1);
    end else begin
      fly_alive = '0;
      wait_sig(2, 1'b1, 30, n);
      chk("clear_latency", n, 2);
    end
    chk("move_en_at_clear", move_en, 0);
    if (m_wave == MW) begin
      chk("won_at_clear", game_won, 1);
      tick();
      chk("clear_single", wave_clear, 0);
      repeat (3) tick();
      chk("won_wave", wave_num, MW);
      chk("won_reset_fly", reset_fly, 0);
      chk("won_move_en", move_en, 0);
      chk("won_level", game_won, 1);
      return;
    end
    tick();
    n = 1;
    chk("clear_single", wave_clear, 0);
    k = $urandom_range(0, 2);
    repeat (k) begin
      tick();
      n++;
    end
    if (pause_len > 0) begin
      pause = 1'b1;
      repeat (pause_len) begin
        tick();
        n++;
      end
      chk("inter_paused_spawn", reset_fly, 0);
      pause = 1'b0;
    end
    wait_sig(0, 1'b1, 60, n2);
    chk("intermission", n + n2, IC + pause_len);
    m_wave++;
    chk("next_wave", wave_num, m_wave);
    chk("next_speed", speed_level, exp_speed(m_wave));
    spawn_to_move("wn");
  endtask

  initial begin
    int n, wc;
    reset_n = 1'b0;
    repeat (2) tick();
    chk("rst_reset_fly", reset_fly, 0);
    chk("rst_move_en", move_en, 0);
    chk("rst_speed", speed_level, 0);
    chk("rst_wave", wave_num, 0);
    chk("rst_clear", wave_clear, 0);
    chk("rst_won", game_won, 0);
    chk("rst_lost", game_lost, 0);
    reset_n = 1'b1;
    tick();

    // Full game to a win.
    start_game();
    active_hold();
    clear_wave(10, 1'b0);
    active_hold();
    clear_wave($urandom_range(0, 5), 1'b1);
    active_hold();
    clear_wave(0, 1'b0);

    // Restart after win, then die on the same cycle alive_q empties.
    start_game();
    active_hold();
    fly_alive = '0;
    tick();
    player_dead = 1'b1;
    tick();
    chk("dead_lost", game_lost, 1);
    chk("dead_no_clear", wave_clear, 0);
    chk("dead_move_en", move_en, 0);
    player_dead = 1'b0;
    rand_alive();
    wc = 0;
    repeat (3) begin
      tick();
      wc += int'(wave_clear);
    end
    chk("dead_no_late_clear", wc, 0);
    chk("dead_lost_level", game_lost, 1);
    chk("dead_reset_fly", reset_fly, 0);

    // Asynchronous reset during SPAWN.
    game_start = 1'b1;
    wait_sig(0, 1'b1, 30, n);
    game_start = 1'b0;
    chk("restart_latency", n, 1);
    #5 reset_n = 1'b0;
    #1;
    chk("async_reset_fly", reset_fly, 0);
    chk("async_wave", wave_num, 0);
    chk("async_lost", game_lost, 0);
    chk("async_move_en", move_en, 0);
    repeat (2) tick();
    reset_n = 1'b1;
    wc = 0;
    repeat (6) begin
      tick();
      wc += int'(reset_fly);
    end
    chk("idle_no_respawn", wc, 0);
    chk("idle_wave", wave_num, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fly_wave_scheduler.md
# fly_wave_scheduler

Sequences successive waves of the 17-fly enemy formation. It pulses `reset_fly` to spawn each wave, watches the flies' alive flags for wave completion, and inserts an intermission between waves. It also tracks the wave number and drives the move enable and speed level consumed by the fly movement logic. It sits between the top-level game FSM (start, pause, player death) and `fly_enemy_controller`, on the 25 MHz pixel clock domain.

## Interface
- `NUM_FLY`, 17: number of alive flags monitored.
- `SPAWN_HOLD`, 2: cycles `reset_fly` is held high per spawn, ≥1.
- `INTERMISSION_CYC`, 25_000_000: idle cycles between waves (1 s at 25 MHz), ≥1.
- `MAX_WAVE`, 8: wave count after which the game is won, 1..255.
- `clk25` input 1: 25 MHz clock; all logic is on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `game_start` input 1: single-cycle request to begin wave 1; honoured only in IDLE, DONE or LOST.
- `pause` input 1: level; freezes all counters and state and deasserts `move_en`.
- `player_dead` input 1: level; aborts the game.
- `fly_alive` input NUM_FLY: alive flags, packed so that bit i is fly i.
- `reset_fly` output 1: spawn pulse to the fly controller.
- `move_en` output 1: flies may advance.
- `speed_level` output 3: movement speed index, 0 is slowest.
- `wave_num` output 8: current wave number; 0 before the first wave.
- `wave_clear` output 1: one-cycle pulse when a wave is fully cleared.
- `game_won` output 1: level; high in DONE.
- `game_lost` output 1: level; high in LOST.

## Operation
- States:
  - IDLE: waits for `game_start`.
  - SPAWN: holds `reset_fly` high and counts SPAWN_HOLD cycles.
  - GUARD: one cycle that lets the alive flags settle after a spawn.
  - ACTIVE: flies move.
  - INTER: intermission countdown.
  - DONE: game won.
  - LOST: game lost.
- `fly_alive` is registered once inside this block (`alive_q`). All decisions use `alive_q`.
- IDLE, DONE or LOST + `game_start`:
  - `wave_num` is set to 1 and `speed_level` to 0.
  - The next state is SPAWN.
- SPAWN:
  - `reset_fly` is 1 for exactly SPAWN_HOLD cycles, then the state moves to GUARD.
  - GUARD always moves to ACTIVE on the next cycle.
- ACTIVE:
  - `move_en` is 1.
  - When `alive_q == 0`, the block pulses `wave_clear` for one cycle.
  - If `wave_num == MAX_WAVE`, the next state is DONE.
  - Otherwise the next state is INTER, with the countdown loaded to INTERMISSION_CYC-1.
- INTER:
  - The countdown decrements each cycle.
  - At 0, `wave_num` increments and the next state is SPAWN.
- `player_dead` in SPAWN, GUARD, ACTIVE or INTER forces LOST on the next cycle.
  - `reset_fly` and `move_en` drop immediately.
  - `player_dead` takes priority over a same-cycle wave clear: no `wave_clear` pulse is issued.
- `pause` high:
  - The state, the SPAWN counter and the INTER counter hold.
  - `move_en` is 0.
  - `reset_fly` keeps its current value.
  - `wave_clear` cannot fire.
  - `player_dead` still takes effect while paused.
- `game_start` outside IDLE, DONE or LOST is ignored.
- `wave_num` never exceeds MAX_WAVE and never wraps.
- In DONE and LOST, all outputs except `game_won`, `game_lost`, `wave_num` and `speed_level` are 0.

## Timing
- Reset values: IDLE; `reset_fly`=0, `move_en`=0, `speed_level`=0, `wave_num`=0, `wave_clear`=0, `game_won`=0, `game_lost`=0.
- All outputs are registered.
- Latencies:
  - `game_start` sampled at edge N: `reset_fly` rises at N+1.
  - `reset_fly` falls at N+1+SPAWN_HOLD.
  - `move_en` rises one cycle after that (the GUARD cycle).
  - `fly_alive` reaching all-zero at edge M: `alive_q` is 0 at M+1, and `wave_clear` plus `move_en`=0 appear at M+2.
  - INTER to SPAWN: `reset_fly` rises INTERMISSION_CYC cycles after `wave_clear`.
- Asserting `reset_n` low mid-wave returns every output to its reset value asynchronously. The flies are not re-spawned until the next `game_start`.

## Configuration
- Macro `FLY_WAVE_SPEEDUP_EN`.
- Defined: on each INTER to SPAWN transition, `speed_level` increments, saturating at 7.
- Undefined: `speed_level` is held at 0 permanently. The increment logic is absent.

## Test plan
Use SPAWN_HOLD=2, INTERMISSION_CYC=4, MAX_WAVE=3.
- Reset, then pulse `game_start`:
  - `reset_fly` is high for 2 cycles.
  - `move_en` rises 1 cycle later.
  - `wave_num`=1.
- In ACTIVE, force `fly_alive`=0:
  - Exactly one `wave_clear`, 2 cycles later.
  - 4 cycles after that, `reset_fly` rises again and `wave_num`=2.
  - `speed_level` is 1 with the macro defined, 0 without it.
- Clear 3 waves:
  - `game_won`=1 and `wave_num` stays at 3.
  - A further `game_start` restarts with `wave_num`=1 and `speed_level`=0.
- Raise `pause` for 10 cycles mid-INTER: the countdown resumes at the held value and the total intermission is 14 cycles.
- Assert `player_dead` in the same cycle that `alive_q` goes 0 in ACTIVE: LOST, no `wave_clear`, `move_en`=0.
- Pull `reset_n` low during SPAWN: `reset_fly`=0 immediately and the block is in IDLE with all outputs at reset values.
